// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - programmable countdown timer (CTRL/PRESET/COUNT), one-shot and auto-reload
// Optional prescaler on COUNT decrements is built when TIMER_PRESCALE_EN is defined.
module timer_dev #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:2]  Addr,
   input  logic        We,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        IRQ
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state, state_nxt;
   logic        en, en_nxt;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count, count_nxt;
   logic        irq_pend, irq_pend_nxt;
   logic        ctrl_we, preset_we, auto_mode, tick;

   assign ctrl_we   = We && (Addr == 2'b00);
   assign preset_we = We && (Addr == 2'b01);
   assign auto_mode = (mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
   logic [15:0] pre_cnt, pre_nxt;

   assign tick = (pre_cnt == 16'(PRESCALE - 1));

   always_comb begin
      pre_nxt = 16'd0;
      if (state == CNT)
         pre_nxt = tick ? 16'd0 : pre_cnt + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pre_cnt <= 16'd0;
      else       pre_cnt <= pre_nxt;
   end
`else
   // No prescaler: every CNT cycle is a decrement opportunity, PRESCALE has no effect.
   assign tick = 1'b1 || (PRESCALE < 2);
`endif

   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      en_nxt       = en;
      irq_pend_nxt = irq_pend;
      if (auto_mode && irq_pend)
         irq_pend_nxt = 1'b0;
      case (state)
         IDLE: if (en) state_nxt = LOAD;
         LOAD: begin
            count_nxt = preset;
            state_nxt = CNT;
         end
         CNT: begin
            if (!en)
               state_nxt = IDLE;
            else if (tick) begin
               if (count == 32'd0) state_nxt = INT;
               else                count_nxt = count - 32'd1;
            end
         end
         INT: begin
            irq_pend_nxt = 1'b1;
            if (auto_mode)
               state_nxt = LOAD;
            else begin
               en_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A CPU write to CTRL overrides the FSM's own En clear and pending set.
      if (ctrl_we) begin
         en_nxt       = DataIn[0];
         irq_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         en       <= 1'b0;
         mode     <= 2'b00;
         im       <= 1'b0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_pend <= 1'b0;
         IRQ      <= 1'b0;
      end else begin
         state    <= state_nxt;
         en       <= en_nxt;
         count    <= count_nxt;
         irq_pend <= irq_pend_nxt;
         IRQ      <= (ctrl_we ? DataIn[3] : im) & irq_pend_nxt;
         if (ctrl_we) begin
            mode <= DataIn[2:1];
            im   <= DataIn[3];
         end
         if (preset_we)
            preset <= DataIn;
      end
   end

   always_comb begin
      DataOut = 32'd0;
      case (Addr)
         2'b00:   DataOut = {28'd0, im, mode, en};
         2'b01:   DataOut = preset;
         2'b10:   DataOut = count;
         default: DataOut = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev against a timeline reference model
module tb_timer_dev;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:2]  Addr = 2'b00;
   logic        We = 1'b0;
   logic [31:0] DataIn = 32'd0;
   logic [31:0] DataOut;
   logic        IRQ;

   timer_dev dut (
      .clk(clk), .reset(reset), .Addr(Addr), .We(We),
      .DataIn(DataIn), .DataOut(DataOut), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  a;
      logic [31:0] d;
      logic        irq;
   } exp_t;

   exp_t sbq[$];
   int passed = 0;
   int total  = 0;

   // Reference model: the timer is either idle or "running", with age = cycles since
   // the reload step. Age 0 reloads, ages 1..L+1 count, age L+2 raises the interrupt.
   logic        m_en, m_im, m_pend, m_irq;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count, m_l;
   bit          m_run;
   int          m_age;

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'b00:   return {28'd0, m_im, m_mode, m_en};
         2'b01:   return m_preset;
         2'b10:   return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_im = 0; m_pend = 0; m_irq = 0; m_mode = 0;
      m_preset = 0; m_count = 0; m_l = 0; m_run = 0; m_age = 0;
   endtask

   task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
      bit          n_run = m_run;
      int          n_age = m_age;
      logic [31:0] n_count = m_count;
      logic        n_en = m_en, n_pend = m_pend, n_im = m_im;
      logic [1:0]  n_mode = m_mode;
      logic [31:0] n_preset = m_preset;
      bit          fire = 0;
      if (!m_run) begin
         if (m_en) begin n_run = 1; n_age = 0; end
      end else if (m_age == 0) begin
         n_count = m_preset; m_l = m_preset; n_age = 1;
      end else if (longint'(m_age) <= longint'(m_l) + 1) begin
         if (!m_en) n_run = 0;
         else begin
            if (longint'(m_age) <= longint'(m_l)) n_count = m_l - 32'(m_age);
            n_age = m_age + 1;
         end
      end else begin
         fire = 1;
         if (m_mode == 2'b01) n_age = 0;
         else begin n_en = 0; n_run = 0; end
      end
      if (m_mode == 2'b01 && m_pend) n_pend = 0;
      if (fire) n_pend = 1;
      if (we && a == 2'b00) begin
         n_en = d[0]; n_mode = d[2:1]; n_im = d[3]; n_pend = 0;
      end
      if (we && a == 2'b01) n_preset = d;
      m_run = n_run; m_age = n_age; m_count = n_count; m_en = n_en; m_pend = n_pend;
      m_im = n_im; m_mode = n_mode; m_preset = n_preset;
      m_irq = n_im & n_pend;
   endtask

   task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      We = we; Addr = a; DataIn = d;
      #1;
      sbq.push_back('{a: a, d: model_read(a), irq: m_irq});
      @(posedge clk);
      if (!reset) model_step(we, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'($urandom_range(0, 3)), $urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 2'(i), $urandom);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic bound_fail(input string what);
      total++;
      $display("FAIL wait_%s actual=timeout required=reached", what);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (DataOut === e.d) passed++;
            else $display("FAIL dataout addr=%0d actual=%h required=%h", e.a, DataOut, e.d);
            total++;
            if (IRQ === e.irq) passed++;
            else $display("FAIL irq actual=%b required=%b", IRQ, e.irq);
         end
      end
   end

   initial begin : stimulus
      int guard;
      model_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 2'(i), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // one-shot
      cycle(1'b1, 2'b01, 32'd5);
      cycle(1'b1, 2'b00, 32'h9);
      idle(14);
      cycle(1'b1, 2'b00, 32'h8);
      idle(3);

      // auto-reload
      cycle(1'b1, 2'b01, 32'd3);
      cycle(1'b1, 2'b00, 32'hB);
      idle(22);
      cycle(1'b1, 2'b00, 32'h0);
      idle(4);

      // pause and resume
      cycle(1'b1, 2'b01, 32'd10);
      cycle(1'b1, 2'b00, 32'h9);
      guard = 0;
      while (!(m_run && m_age >= 1 && m_count == 32'd6) && guard < 60) begin idle(1); guard++; end
      if (guard >= 60) bound_fail("count6");
      cycle(1'b1, 2'b00, 32'h8);
      idle(6);
      cycle(1'b1, 2'b00, 32'h9);
      idle(18);

      // masked interrupt with PRESET=0
      cycle(1'b1, 2'b01, 32'd0);
      cycle(1'b1, 2'b00, 32'h1);
      idle(6);
      cycle(1'b1, 2'b00, 32'h8);
      idle(3);

      // ignored writes
      cycle(1'b1, 2'b10, 32'h1234);
      cycle(1'b1, 2'b11, 32'hFFFF_FFFF);
      idle(3);

      // CTRL write colliding with the one-shot interrupt step
      cycle(1'b1, 2'b01, 32'd2);
      cycle(1'b1, 2'b00, 32'h9);
      guard = 0;
      while (!(m_run && longint'(m_age) == longint'(m_l) + 2) && guard < 60) begin idle(1); guard++; end
      if (guard >= 60) bound_fail("int");
      cycle(1'b1, 2'b00, 32'h9);
      idle(12);

      // reset in the middle of a count
      cycle(1'b1, 2'b01, 32'd20);
      cycle(1'b1, 2'b00, 32'hB);
      idle(9);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] a = 2'($urandom_range(0, 3));
         logic       w = ($urandom_range(0, 9) == 0);
         logic [31:0] d = $urandom;
         if (a == 2'b01) d = $urandom_range(0, 12);
         if (a == 2'b00 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         cycle(w, a, d);
         if ($urandom_range(0, 1499) == 0) do_reset();
      end

      @(negedge clk);
      #5;
      if (sbq.size() != 0) begin
         total++;
         $display("FAIL drain actual=%0d required=0", sbq.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
